// File: rtl/branch_cond_unit_pkg.sv
// Shared encodings for the branch condition unit: condition codes, FSM states
// and ALU flag bit positions.
package branch_cond_unit_pkg;

  typedef enum logic [2:0] {
    CC_BRZR   = 3'd0,
    CC_BRNZ   = 3'd1,
    CC_BRPL   = 3'd2,
    CC_BRMI   = 3'd3,
    CC_NEVER  = 3'd4,
    CC_ALWAYS = 3'd5,
    CC_BRCS   = 3'd6,
    CC_BRVS   = 3'd7
  } cc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_cond_unit_cond_decoder_3to8.sv
// One-hot select for the eight branch condition codes.
module cond_decoder_3to8
  import branch_cond_unit_pkg::*;
(
  input  cc_e        cc,
  output logic [7:0] sel
);

  // NOTE: sel is assigned on every path, so no latch is inferred.
  always_comb begin
    sel = 8'b0;
    sel[cc] = 1'b1;
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Two-state branch condition evaluator: captures operand and condition code on
// a CONin strobe, produces a registered CON flag one edge later.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CC_LSB = 19,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] busin,
  input  logic [31:0]       ir,
  input  logic              CONin,
  input  logic [3:0]        flags_in,
  input  logic              flags_we,
  output logic              out,
  output logic              con_valid,
  output logic              busy,
  output logic [STAT_W-1:0] taken_cnt
);

  state_e            state, next_state;
  logic [DATA_W-1:0] cap_bus;
  cc_e               cap_cc;
  logic [3:0]        flags;
  logic [7:0]        sel;
  logic [7:0]        cond_vec;
  logic              result;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= ST_IDLE;
    else       state <= next_state;
  end

  // A strobe arriving in EVAL is dropped, not queued.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (CONin) next_state = ST_EVAL;
      ST_EVAL: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cap_bus <= '0;
      cap_cc  <= CC_BRZR;
    end else if (state == ST_IDLE && CONin) begin
      cap_bus <= busin;
      cap_cc  <= cc_e'(ir[CC_LSB+2:CC_LSB]);
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)         flags <= '0;
    else if (flags_we) flags <= flags_in;
  end

  cond_decoder_3to8 u_dec (
    .cc  (cap_cc),
    .sel (sel)
  );

  // Bit i of cond_vec is the truth value of condition code i.
  assign cond_vec = {flags[FLAG_V], flags[FLAG_C], 1'b1, 1'b0,
                     cap_bus[DATA_W-1], ~cap_bus[DATA_W-1],
                     |cap_bus, ~|cap_bus};
  assign result   = |(sel & cond_vec);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      out       <= 1'b0;
      con_valid <= 1'b0;
      taken_cnt <= '0;
    end else begin
      con_valid <= (state == ST_EVAL);
      if (state == ST_EVAL) begin
        out <= result;
        if (result && taken_cnt != {STAT_W{1'b1}}) taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == ST_EVAL);

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench: a default-width unit and a 2-bit-counter unit share stimulus.
module tb_branch_cond_unit;

  logic        clock = 1'b0;
  logic        clear, CONin, flags_we;
  logic [31:0] busin, ir;
  logic [3:0]  flags_in;
  logic        out_a, cv_a, busy_a, out_b, cv_b, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  typedef struct {
    logic out;
    int   taken;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         m_taken = 0;
  logic [3:0] m_flags = 4'b0;

  always #5 clock = ~clock;

  branch_cond_unit dut_a (
    .clock(clock), .clear(clear), .busin(busin), .ir(ir), .CONin(CONin),
    .flags_in(flags_in), .flags_we(flags_we), .out(out_a), .con_valid(cv_a),
    .busy(busy_a), .taken_cnt(cnt_a)
  );

  branch_cond_unit #(.STAT_W(2)) dut_b (
    .clock(clock), .clear(clear), .busin(busin), .ir(ir), .CONin(CONin),
    .flags_in(flags_in), .flags_we(flags_we), .out(out_b), .con_valid(cv_b),
    .busy(busy_b), .taken_cnt(cnt_b)
  );

  function automatic logic [31:0] mk_ir(input logic [2:0] cc);
    logic [31:0] r;
    r = $urandom & ~(32'h7 << 19);
    return r | (32'(cc) << 19);
  endfunction

  function automatic logic model_cond(input logic [31:0] b, input logic [2:0] cc,
                                      input logic [3:0] f);
    case (cc)
      3'd0: return b == 32'd0;
      3'd1: return b != 32'd0;
      3'd2: return b[31] == 1'b0;
      3'd3: return b[31] == 1'b1;
      3'd4: return 1'b0;
      3'd5: return 1'b1;
      3'd6: return f[1];
      default: return f[0];
    endcase
  endfunction

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One full evaluation with optional flag writes on the capture and EVAL edges.
  task automatic run_eval(input logic [31:0] b, input logic [2:0] cc,
                          input logic fw_cap, input logic [3:0] fv_cap,
                          input logic fw_eval, input logic [3:0] fv_eval,
                          input string name);
    exp_t e;
    logic held;
    @(negedge clock);
    busin = b; ir = mk_ir(cc); CONin = 1'b1; flags_we = fw_cap; flags_in = fv_cap;
    @(posedge clock); #1;
    if (fw_cap) m_flags = fv_cap;
    e.out = model_cond(b, cc, m_flags);
    if (e.out) m_taken++;
    e.taken = m_taken;
    exp_q.push_back(e);
    tests++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || cv_a !== 1'b0) begin
      fails++;
      $display("FAIL %s busy: got busy=%b/%b cv=%b, want busy=1 cv=0", name, busy_a, busy_b, cv_a);
    end
    @(negedge clock);
    CONin = 1'b0; busin = ~b; ir = mk_ir(~cc); flags_we = fw_eval; flags_in = fv_eval;
    @(posedge clock); #1;
    if (fw_eval) m_flags = fv_eval;
    e = exp_q.pop_front();
    tests++;
    if (out_a !== e.out || out_b !== e.out || cv_a !== 1'b1 || cv_b !== 1'b1 ||
        busy_a !== 1'b0 || cnt_a !== 16'(clampi(e.taken, 65535)) ||
        cnt_b !== 2'(clampi(e.taken, 3))) begin
      fails++;
      $display("FAIL %s result: got out=%b/%b cv=%b/%b busy=%b cnt=%0d/%0d, want out=%b cv=1 busy=0 cnt=%0d/%0d",
               name, out_a, out_b, cv_a, cv_b, busy_a, cnt_a, cnt_b, e.out,
               clampi(e.taken, 65535), clampi(e.taken, 3));
    end
    held = e.out;
    @(negedge clock); flags_we = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (cv_a !== 1'b0 || cv_b !== 1'b0 || out_a !== held) begin
      fails++;
      $display("FAIL %s hold: got cv=%b/%b out=%b, want cv=0 out=%b", name, cv_a, cv_b, out_a, held);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b1; CONin = 1'b0; flags_we = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    m_taken = 0; m_flags = 4'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear = 1'b1; CONin = 1'b0; flags_we = 1'b0; busin = '0; ir = '0; flags_in = '0;
    #12;
    tests++;
    if (out_a !== 1'b0 || cv_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 2'd0) begin
      fails++;
      $display("FAIL reset: got out=%b cv=%b busy=%b cnt=%0d/%0d, want all 0", out_a, cv_a, busy_a, cnt_a, cnt_b);
    end
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_zero();
    run_eval(32'd0, 3'd0, 1'b0, 4'h0, 1'b0, 4'h0, "brzr_zero");
    run_eval(32'd5, 3'd0, 1'b0, 4'h0, 1'b0, 4'h0, "brzr_five");
    run_eval(32'd5, 3'd1, 1'b0, 4'h0, 1'b0, 4'h0, "brnz_five");
  endtask

  task automatic test_sign();
    run_eval(32'h8000_0000, 3'd3, 1'b0, 4'h0, 1'b0, 4'h0, "brmi_neg");
    run_eval(32'h8000_0000, 3'd2, 1'b0, 4'h0, 1'b0, 4'h0, "brpl_neg");
    run_eval(32'h7FFF_FFFF, 3'd2, 1'b0, 4'h0, 1'b0, 4'h0, "brpl_pos");
    run_eval(32'h1234_5678, 3'd4, 1'b0, 4'h0, 1'b0, 4'h0, "never");
  endtask

  task automatic test_flags();
    run_eval(32'd0, 3'd6, 1'b1, 4'b0010, 1'b0, 4'h0, "brcs_cap_write");
    run_eval(32'd0, 3'd6, 1'b0, 4'h0, 1'b1, 4'b0000, "brcs_eval_write");
    run_eval(32'd0, 3'd6, 1'b0, 4'h0, 1'b0, 4'h0, "brcs_cleared");
    run_eval(32'd0, 3'd7, 1'b1, 4'b0001, 1'b0, 4'h0, "brvs_set");
    run_eval(32'd0, 3'd7, 1'b1, 4'b1110, 1'b0, 4'h0, "brvs_clear");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int start_taken;
    start_taken = m_taken;
    @(negedge clock); busin = '0; ir = mk_ir(3'd5); CONin = 1'b1;
    @(posedge clock);
    @(negedge clock); ir = mk_ir(3'd5);
    @(posedge clock); #1;
    m_taken++;
    tests++;
    if (cv_a !== 1'b1 || out_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL b2b first: got cv=%b out=%b busy=%b, want cv=1 out=1 busy=0", cv_a, out_a, busy_a);
    end
    @(negedge clock); CONin = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (cv_a === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || cnt_a !== 16'(start_taken + 1)) begin
      fails++;
      $display("FAIL b2b single: got extra_pulses=%0d cnt=%0d, want 0 and %0d", pulses, cnt_a, start_taken + 1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) run_eval($urandom, 3'd5, 1'b0, 4'h0, 1'b0, 4'h0, "sat_always");
    tests++;
    if (cnt_b !== 2'd3 || cnt_a !== 16'd4) begin
      fails++;
      $display("FAIL saturation: got cnt=%0d/%0d, want 4/3", cnt_a, cnt_b);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clock); busin = '0; ir = mk_ir(3'd5); CONin = 1'b1;
    @(posedge clock); #2;
    clear = 1'b1;
    #1;
    tests++;
    if (out_a !== 1'b0 || cnt_a !== 16'd0 || cnt_b !== 2'd0 || busy_a !== 1'b0 || cv_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got out=%b cnt=%0d/%0d busy=%b cv=%b, want all 0", out_a, cnt_a, cnt_b, busy_a, cv_a);
    end
    @(posedge clock); #1;
    @(negedge clock); clear = 1'b0; CONin = 1'b0;
    m_taken = 0; m_flags = 4'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (cv_a === 1'b1 || busy_a === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || out_a !== 1'b0 || cnt_a !== 16'd0) begin
      fails++;
      $display("FAIL reset_ignore_strobe: got activity=%0d out=%b cnt=%0d, want 0 0 0", pulses, out_a, cnt_a);
    end
    run_eval(32'd0, 3'd0, 1'b0, 4'h0, 1'b0, 4'h0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sign();
    test_flags();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of busin, the operand under test.
REQ-002 Parameter CC_LSB, default 19: LSB of the 3-bit condition field in ir, ir[CC_LSB+2:CC_LSB].
REQ-003 Parameter STAT_W, default 16: width of the taken-branch counter.
REQ-004 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port clear  input  1  reset, asynchronous and active-high.
REQ-006 Port busin  input  DATA_W  operand value tested for the branch.
REQ-007 Port ir  input  32  current instruction register.
REQ-008 Port CONin  input  1  evaluate strobe, sampled on the rising edge of clock.
REQ-009 Port flags_in  input  4  {N,Z,C,V} from the ALU.
REQ-010 Port flags_we  input  1  load flags_in into the flags register.
REQ-011 Port out  output  1  registered branch-taken (CON) flag.
REQ-012 Port con_valid  output  1  one-cycle pulse when out has just been updated.
REQ-013 Port busy  output  1  high while the FSM is in EVAL.
REQ-014 Port taken_cnt  output  STAT_W  saturating count of taken evaluations.

Function
REQ-015 The condition codes SHALL be: 0 BRZR (busin==0), 1 BRNZ (busin!=0), 2 BRPL (busin[DATA_W-1]==0), 3 BRMI (busin[DATA_W-1]==1), 4 NEVER, 5 ALWAYS, 6 BRCS (stored C==1), 7 BRVS (stored V==1).
REQ-016 The FSM SHALL have two states, IDLE and EVAL.
REQ-017 In IDLE with CONin=1 at an edge, the unit SHALL capture busin and the condition code into internal registers and enter EVAL.
REQ-018 In EVAL, the unit SHALL evaluate the captured condition, load the result into out, pulse con_valid, and return to IDLE on the next edge.
REQ-019 Latency: CONin sampled at edge k SHALL update out and assert con_valid after edge k+1, with con_valid low after edge k+2 unless a new evaluation completes.
REQ-020 CONin while in EVAL SHALL be ignored and SHALL NOT be queued.
REQ-021 Back-to-back strobes SHALL therefore complete at most one evaluation per two cycles.
REQ-022 out SHALL hold its value between evaluations.
REQ-023 busin and ir changes after the capture edge SHALL NOT affect the result.
REQ-024 The flags register SHALL load flags_in on any edge with flags_we=1, regardless of FSM state.
REQ-025 BRCS/BRVS SHALL use the flags register contents during the EVAL cycle, so flags_we coincident with the capture edge is visible and flags_we during EVAL is not.
REQ-026 taken_cnt SHALL increment by 1 on each evaluation whose result is 1 and SHALL hold at all-ones (2^STAT_W-1).
REQ-027 busy SHALL equal (state==EVAL).

Reset
REQ-028 clear=1 SHALL asynchronously force: state=IDLE, out=0, con_valid=0, busy=0, taken_cnt=0, flags register=0, capture registers=0.
REQ-029 clear asserted mid-EVAL SHALL abort the evaluation with no update to out or taken_cnt.
REQ-030 CONin SHALL be ignored on any edge where clear is high.

Structure
REQ-031 The condition-code encodings (0..7), the state encoding and the flag bit indices (N=3, Z=2, C=1, V=0) SHALL live in a shared package.
REQ-032 The condition-code to one-hot select SHALL be a sub-module, cond_decoder_3to8.

Verification
REQ-033 Zero case: busin=0, cc=0, CONin pulse -> out=1 and con_valid=1 after 2nd edge, taken_cnt=1; repeating with busin=5 -> out=0, taken_cnt stays 1.
REQ-034 Sign case: busin=0x8000_0000, cc=3 -> out=1; cc=2 -> out=0; busin=0x7FFF_FFFF, cc=2 -> out=1.
REQ-035 Flags timing: flags_in=4'b0010, flags_we with CONin (cc=6) -> out=1; flags_we=1 with flags_in=0 during EVAL of next cc=6 strobe -> out=1 again (old C used).
REQ-036 Strobe during EVAL: CONin high 2 cycles, cc=5 -> exactly one con_valid pulse, taken_cnt increments by 1.
REQ-037 Saturation: STAT_W=2, four cc=5 evaluations -> taken_cnt reads 1,2,3,3.
REQ-038 Reset mid-op: clear pulsed during EVAL of cc=5 -> out=0, taken_cnt=0, state IDLE, no con_valid.
